// File: rtl/alu_ctrl_dm.sv
// Instruction decoder, 32-bit ALU and big-endian byte-addressed data memory.
// Optional byte loads/stores (lb/sb, dm_len) are enabled by ALU_CTRL_DM_BYTE_ACCESS_EN.
module alu_ctrl_dm #(
  parameter int DM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [18:0] ctrl,
  input  logic [2:0]  alu_ctr,
  input  logic [31:0] alu_a,
  input  logic [31:0] alu_b,
  output logic [31:0] alu_res,
  output logic        alu_zero,
  output logic        alu_wrctr,
  input  logic [31:0] dm_addr,
  input  logic        dm_rd,
  input  logic        dm_wr,
  input  logic        dm_len,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata
);

  localparam int AW = $clog2(DM_BYTES);

  // Field order matches the packed ctrl bus, MSB (pcwre) first.
  typedef struct packed {
    logic       pcwre;
    logic [2:0] aluctr;
    logic       regdst;
    logic       regwre;
    logic       rd;
    logic       wr;
    logic       dbdatasrc;
    logic       dmdatasize;
    logic       alusrc_a;
    logic       alusrc_b;
    logic       jump;
    logic       branch_eq;
    logic       branch_ne;
    logic       branch_lt;
    logic       link;
    logic       jr;
    logic       extsign;
  } ctrl_t;

  ctrl_t c;

  always_comb begin
    c = '0;
    case (opcode)
      6'b000000: begin
        c.regdst = 1'b1;
        c.regwre = 1'b1;
        case (funct)
          6'b100000: c.aluctr = 3'b000;
          6'b100010: c.aluctr = 3'b001;
          6'b000000: begin
            c.aluctr   = 3'b010;
            c.alusrc_a = 1'b1;
          end
          6'b100101: c.aluctr = 3'b011;
          6'b100100: c.aluctr = 3'b100;
          6'b101010: c.aluctr = 3'b101;
          6'b100110: c.aluctr = 3'b110;
          6'b001011: c.aluctr = 3'b111;
          6'b001000: begin
            c    = '0;
            c.jr = 1'b1;
          end
          default: c = '0;
        endcase
      end
      6'b001000: begin
        c.regwre   = 1'b1;
        c.alusrc_b = 1'b1;
        c.extsign  = 1'b1;
      end
      6'b001101: begin
        c.regwre   = 1'b1;
        c.alusrc_b = 1'b1;
        c.aluctr   = 3'b011;
      end
      6'b001100: begin
        c.regwre   = 1'b1;
        c.alusrc_b = 1'b1;
        c.aluctr   = 3'b100;
      end
      6'b001010: begin
        c.regwre   = 1'b1;
        c.alusrc_b = 1'b1;
        c.aluctr   = 3'b101;
        c.extsign  = 1'b1;
      end
      6'b100011: begin
        c.regwre    = 1'b1;
        c.alusrc_b  = 1'b1;
        c.extsign   = 1'b1;
        c.rd        = 1'b1;
        c.dbdatasrc = 1'b1;
      end
      6'b101011: begin
        c.wr       = 1'b1;
        c.alusrc_b = 1'b1;
        c.extsign  = 1'b1;
      end
`ifdef ALU_CTRL_DM_BYTE_ACCESS_EN
      6'b100000: begin
        c.regwre     = 1'b1;
        c.alusrc_b   = 1'b1;
        c.extsign    = 1'b1;
        c.rd         = 1'b1;
        c.dbdatasrc  = 1'b1;
        c.dmdatasize = 1'b1;
      end
      6'b101000: begin
        c.wr         = 1'b1;
        c.alusrc_b   = 1'b1;
        c.extsign    = 1'b1;
        c.dmdatasize = 1'b1;
      end
`endif
      6'b000100: begin
        c.branch_eq = 1'b1;
        c.aluctr    = 3'b001;
      end
      6'b000101: begin
        c.branch_ne = 1'b1;
        c.aluctr    = 3'b001;
      end
      6'b000001: begin
        c.branch_lt = 1'b1;
        c.aluctr    = 3'b001;
      end
      6'b000010: c.jump = 1'b1;
      6'b000011: begin
        c.link   = 1'b1;
        c.regwre = 1'b1;
      end
      6'b111111: c.pcwre = 1'b1;
      default:   c = '0;
    endcase
  end

  assign ctrl = c;

  always_comb begin
    alu_res   = '0;
    alu_wrctr = 1'b1;
    case (alu_ctr)
      3'b000: begin
        alu_res = alu_a + alu_b;
        // Signed overflow: same-sign operands giving a result of the other sign.
        alu_wrctr = !((alu_a[31] == alu_b[31]) && (alu_res[31] != alu_a[31]));
      end
      3'b001: alu_res = alu_a - alu_b;
      3'b010: alu_res = alu_b << alu_a[4:0];
      3'b011: alu_res = alu_a | alu_b;
      3'b100: alu_res = alu_a & alu_b;
      3'b101: alu_res = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      3'b110: alu_res = alu_a ^ alu_b;
      default: begin
        alu_res   = alu_a;
        alu_wrctr = (alu_b != 32'd0);
      end
    endcase
  end

  assign alu_zero = (alu_res == 32'd0);

  logic [7:0]    mem [DM_BYTES];
  logic [AW-1:0] addr;
  logic [AW-1:0] a0, a1, a2, a3;
  logic          is_byte;
  logic [31:0]   rd_word;
  logic          unused_ok;

  assign addr = dm_addr[AW-1:0];
  assign a0   = {addr[AW-1:2], 2'b00};
  assign a1   = {addr[AW-1:2], 2'b01};
  assign a2   = {addr[AW-1:2], 2'b10};
  assign a3   = {addr[AW-1:2], 2'b11};

`ifdef ALU_CTRL_DM_BYTE_ACCESS_EN
  assign is_byte = dm_len;
`else
  assign is_byte = 1'b0;
`endif

  assign unused_ok = ^{dm_addr[31:AW], dm_len};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_BYTES; i++) mem[i] <= '0;
    end else if (dm_wr) begin
      if (is_byte) begin
        mem[addr] <= dm_wdata[7:0];
      end else begin
        mem[a0] <= dm_wdata[31:24];
        mem[a1] <= dm_wdata[23:16];
        mem[a2] <= dm_wdata[15:8];
        mem[a3] <= dm_wdata[7:0];
      end
    end
  end

  // Big-endian: the lowest address holds the most significant byte.
  assign rd_word = {mem[a0], mem[a1], mem[a2], mem[a3]};

  always_comb begin
    dm_rdata = '0;
    if (dm_rd) begin
      if (is_byte) dm_rdata = {{24{mem[addr][7]}}, mem[addr]};
      else         dm_rdata = rd_word;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_dm.sv
// Directed bench for alu_ctrl_dm: table-driven decode and ALU vectors plus
// hand-written data-memory sequences (byte cases follow ALU_CTRL_DM_BYTE_ACCESS_EN).
module tb_alu_ctrl_dm;

  logic        clk;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [18:0] ctrl;
  logic [2:0]  alu_ctr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;
  logic        alu_zero;
  logic        alu_wrctr;
  logic [31:0] dm_addr;
  logic        dm_rd;
  logic        dm_wr;
  logic        dm_len;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  alu_ctrl_dm #(.DM_BYTES(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .opcode    (opcode),
    .funct     (funct),
    .ctrl      (ctrl),
    .alu_ctr   (alu_ctr),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_res   (alu_res),
    .alu_zero  (alu_zero),
    .alu_wrctr (alu_wrctr),
    .dm_addr   (dm_addr),
    .dm_rd     (dm_rd),
    .dm_wr     (dm_wr),
    .dm_len    (dm_len),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [18:0] exp;
  } ctrl_vec_t;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_res;
    logic        exp_zero;
    logic        exp_wr;
  } alu_vec_t;

  localparam int N_CV = 25;
  localparam int N_AV = 15;
  ctrl_vec_t cv [N_CV];
  alu_vec_t  av [N_AV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mem_read(input logic [31:0] a, input logic len);
    dm_wr   = 1'b0;
    dm_rd   = 1'b1;
    dm_addr = a;
    dm_len  = len;
    #1;
  endtask

  task automatic mem_write(input logic [31:0] a, input logic len, input logic [31:0] d);
    dm_wr    = 1'b1;
    dm_rd    = 1'b0;
    dm_addr  = a;
    dm_len   = len;
    dm_wdata = d;
    tick();
    dm_wr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct = '0; alu_ctr = '0; alu_a = '0; alu_b = '0;
    dm_addr = '0; dm_rd = 1'b0; dm_wr = 1'b0; dm_len = 1'b0; dm_wdata = '0;

    // Decode table: {opcode, funct, expected ctrl}
    cv[0]  = '{6'h00, 6'b100000, 19'h06000};
    cv[1]  = '{6'h00, 6'b100010, 19'h0E000};
    cv[2]  = '{6'h00, 6'b000000, 19'h16100};
    cv[3]  = '{6'h00, 6'b100101, 19'h1E000};
    cv[4]  = '{6'h00, 6'b100100, 19'h26000};
    cv[5]  = '{6'h00, 6'b101010, 19'h2E000};
    cv[6]  = '{6'h00, 6'b100110, 19'h36000};
    cv[7]  = '{6'h00, 6'b001011, 19'h3E000};
    cv[8]  = '{6'h00, 6'b001000, 19'h00002};
    cv[9]  = '{6'h00, 6'b111111, 19'h00000};
    cv[10] = '{6'b001000, 6'h20, 19'h02081};
    cv[11] = '{6'b001101, 6'h20, 19'h1A080};
    cv[12] = '{6'b001100, 6'h2A, 19'h22080};
    cv[13] = '{6'b001010, 6'h08, 19'h2A081};
    cv[14] = '{6'b100011, 6'h15, 19'h03481};
    cv[15] = '{6'b101011, 6'h20, 19'h00881};
    cv[16] = '{6'b000100, 6'h20, 19'h08020};
    cv[17] = '{6'b000101, 6'h00, 19'h08010};
    cv[18] = '{6'b000001, 6'h00, 19'h08008};
    cv[19] = '{6'b000010, 6'h08, 19'h00040};
    cv[20] = '{6'b000011, 6'h00, 19'h02004};
    cv[21] = '{6'b111111, 6'h2A, 19'h40000};
    cv[22] = '{6'b010101, 6'h20, 19'h00000};
`ifdef ALU_CTRL_DM_BYTE_ACCESS_EN
    cv[23] = '{6'b100000, 6'h00, 19'h03681};
    cv[24] = '{6'b101000, 6'h00, 19'h00A81};
`else
    cv[23] = '{6'b100000, 6'h00, 19'h00000};
    cv[24] = '{6'b101000, 6'h00, 19'h00000};
`endif

    // ALU table: {op, a, b, res, zero, wrctr}
    av[0]  = '{3'b000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1'b0, 1'b0};
    av[1]  = '{3'b000, 32'h00000003, 32'h00000004, 32'h00000007, 1'b0, 1'b1};
    av[2]  = '{3'b000, 32'h80000000, 32'h80000000, 32'h00000000, 1'b1, 1'b0};
    av[3]  = '{3'b000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
    av[4]  = '{3'b001, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1, 1'b1};
    av[5]  = '{3'b001, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b1};
    av[6]  = '{3'b010, 32'h00000004, 32'h00000001, 32'h00000010, 1'b0, 1'b1};
    av[7]  = '{3'b010, 32'h00000025, 32'h00000003, 32'h00000060, 1'b0, 1'b1};
    av[8]  = '{3'b011, 32'hF0F00000, 32'h00000F0F, 32'hF0F00F0F, 1'b0, 1'b1};
    av[9]  = '{3'b100, 32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00, 1'b0, 1'b1};
    av[10] = '{3'b101, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 1'b0, 1'b1};
    av[11] = '{3'b101, 32'h00000005, 32'hFFFFFFFD, 32'h00000000, 1'b1, 1'b1};
    av[12] = '{3'b110, 32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 1'b0, 1'b1};
    av[13] = '{3'b111, 32'h00000009, 32'h00000000, 32'h00000009, 1'b0, 1'b0};
    av[14] = '{3'b111, 32'h00000000, 32'h00000003, 32'h00000000, 1'b1, 1'b1};

    // Combinational blocks are checked while reset is still asserted.
    for (int i = 0; i < N_CV; i++) begin
      opcode = cv[i].op;
      funct  = cv[i].fn;
      #1;
      check($sformatf("ctrl[%0d] op=%b fn=%b", i, cv[i].op, cv[i].fn), {13'd0, ctrl}, {13'd0, cv[i].exp});
    end

    for (int i = 0; i < N_AV; i++) begin
      alu_ctr = av[i].op;
      alu_a   = av[i].a;
      alu_b   = av[i].b;
      #1;
      check($sformatf("alu_res[%0d]", i),   alu_res,          av[i].exp_res);
      check($sformatf("alu_zero[%0d]", i),  {31'd0, alu_zero},  {31'd0, av[i].exp_zero});
      check($sformatf("alu_wrctr[%0d]", i), {31'd0, alu_wrctr}, {31'd0, av[i].exp_wr});
    end

    tick();
    tick();
    reset = 1'b0;

    // Memory is clear after reset, including wrapped addresses.
    mem_read(32'h0, 1'b0);        check("rst_rd_0",   dm_rdata, 32'h0);
    mem_read(32'hFC, 1'b0);       check("rst_rd_fc",  dm_rdata, 32'h0);
    mem_read(32'h1234_5678, 1'b0); check("rst_rd_hi", dm_rdata, 32'h0);

    // Same-cycle read of the address being written returns old data.
    dm_wr = 1'b1; dm_rd = 1'b1; dm_addr = 32'd8; dm_len = 1'b0; dm_wdata = 32'h11223344;
    #1;
    check("rd_during_wr_old", dm_rdata, 32'h0);
    tick();
    dm_wr = 1'b0;
    mem_read(32'd8, 1'b0);   check("word_rd_8",      dm_rdata, 32'h11223344);
    mem_read(32'd10, 1'b0);  check("word_rd_10_align", dm_rdata, 32'h11223344);
    mem_read(32'd264, 1'b0); check("word_rd_wrap",   dm_rdata, 32'h11223344);
    mem_read(32'd4, 1'b0);   check("word_rd_4_clean", dm_rdata, 32'h0);
    dm_rd = 1'b0; #1;        check("rd_disabled",    dm_rdata, 32'h0);

`ifdef ALU_CTRL_DM_BYTE_ACCESS_EN
    mem_read(32'd9, 1'b1);   check("byte_rd_9",  dm_rdata, 32'h00000022);
    mem_read(32'd8, 1'b1);   check("byte_rd_8",  dm_rdata, 32'h00000011);
`else
    mem_read(32'd9, 1'b1);   check("len1_rd_9_word", dm_rdata, 32'h11223344);
`endif

    mem_write(32'd3, 1'b1, 32'h000000AB);
`ifdef ALU_CTRL_DM_BYTE_ACCESS_EN
    mem_read(32'd3, 1'b1);   check("byte_rd_3_sext", dm_rdata, 32'hFFFFFFAB);
`else
    mem_read(32'd3, 1'b1);   check("len1_rd_3_word", dm_rdata, 32'h000000AB);
`endif
    mem_read(32'd0, 1'b0);   check("word_rd_0_after_byte", dm_rdata, 32'h000000AB);
    mem_read(32'd8, 1'b0);   check("word_rd_8_intact", dm_rdata, 32'h11223344);

    mem_write(32'd272, 1'b0, 32'hDEADBEEF);
    mem_read(32'd16, 1'b0);  check("wrap_wr_rd_16", dm_rdata, 32'hDEADBEEF);

    // Reset clears memory and suppresses a write in the same cycle.
    reset = 1'b1; dm_wr = 1'b1; dm_rd = 1'b0; dm_addr = 32'd20; dm_len = 1'b0; dm_wdata = 32'h55AA55AA;
    tick();
    reset = 1'b0; dm_wr = 1'b0;
    mem_read(32'd8, 1'b0);   check("post_rst_rd_8",  dm_rdata, 32'h0);
    mem_read(32'd16, 1'b0);  check("post_rst_rd_16", dm_rdata, 32'h0);
    mem_read(32'd20, 1'b0);  check("rst_wr_ignored", dm_rdata, 32'h0);
    mem_read(32'd0, 1'b0);   check("post_rst_rd_0",  dm_rdata, 32'h0);

    // ALU stays combinational across reset.
    reset = 1'b1; alu_ctr = 3'b000; alu_a = 32'd10; alu_b = 32'd20;
    #1;
    check("alu_under_reset", alu_res, 32'd30);
    tick();
    reset = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_dm.md
ALU_CTRL_DM -- requirements
Module: alu_ctrl_dm

Interface
REQ-001 Parameter: DM_BYTES, default 256, data-memory size in bytes; power of two, minimum 8.
REQ-002 clk  in  1  single clock; every state change occurs on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 opcode  in  6  instruction bits [31:26].
REQ-005 funct  in  6  instruction bits [5:0].
REQ-006 ctrl  out  19  decoded controls: [18]pcwre(halt) [17:15]aluctr [14]regdst [13]regwre [12]rd [11]wr [10]dbdatasrc [9]dmdatasize [8]alusrcA [7]alusrcB [6]jump [5]branch_eq [4]branch_ne [3]branch_lt [2]link [1]jr [0]extsign.
REQ-007 alu_ctr  in  3  ALU operation select.
REQ-008 alu_a  in  32  ALU operand A; the shift amount for SLL.
REQ-009 alu_b  in  32  ALU operand B.
REQ-010 alu_res  out  32  ALU result.
REQ-011 alu_zero  out  1  high when alu_res == 0.
REQ-012 alu_wrctr  out  1  register-write qualifier (low = suppress the write).
REQ-013 dm_addr  in  32  byte address; only the low log2(DM_BYTES) bits are used.
REQ-014 dm_rd  in  1  read enable.
REQ-015 dm_wr  in  1  write enable.
REQ-016 dm_len  in  1  access size: 0 = word, 1 = byte.
REQ-017 dm_wdata  in  32  store data.
REQ-018 dm_rdata  out  32  load data.

Function
REQ-019 ctrl SHALL be a purely combinational function of opcode and funct; every bit not listed for a decode SHALL be 0.
REQ-020 R-type decodes (opcode 000000) SHALL set regdst=1 and regwre=1, with aluctr by funct: 100000 add→000; 100010 sub→001; 000000 sll→010 with alusrcA=1; 100101 or→011; 100100 and→100; 101010 slt→101; 100110 xor→110; 001011 movn→111.
REQ-021 R-type funct 001000 (jr) SHALL set jr=1 only; any other R-type funct SHALL produce ctrl=0.
REQ-022 I-type decodes SHALL set regwre=1 and alusrcB=1, as follows: addi 001000: aluctr=000, extsign=1; ori 001101: aluctr=011; andi 001100: aluctr=100; slti 001010: aluctr=101, extsign=1.
REQ-023 lw 100011 SHALL set regwre, alusrcB, extsign, rd and dbdatasrc, with aluctr=000; sw 101011 SHALL set wr, alusrcB and extsign, with aluctr=000.
REQ-024 beq 000100 SHALL set branch_eq=1; bne 000101 SHALL set branch_ne=1; bltz 000001 SHALL set branch_lt=1; all three SHALL use aluctr=001.
REQ-025 j 000010 SHALL set jump=1; jal 000011 SHALL set link=1 and regwre=1; halt 111111 SHALL set pcwre=1; any unlisted opcode SHALL produce ctrl=0.
REQ-026 ALU SHALL be combinational, by alu_ctr: 000 a+b; 001 a-b; 010 b<<a[4:0]; 011 a|b; 100 a&b; 101 signed a<b ? 1 : 0; 110 a^b; 111 res=a (movn).
REQ-027 alu_wrctr SHALL be: for 000, 0 on signed overflow and 1 otherwise; for 111, (b != 0); for every other op, 1.
REQ-028 Arithmetic SHALL wrap modulo 2^32; alu_zero SHALL reflect alu_res for every op.
REQ-029 DM SHALL be byte-addressed and big-endian; a word access SHALL force address bits [1:0] to 00.
REQ-030 A DM write SHALL commit at the rising clk edge when dm_wr=1; a word write stores dm_wdata, a byte write stores dm_wdata[7:0].
REQ-031 A DM read SHALL be combinational: with dm_rd=1, dm_rdata is the word, or the sign-extended byte; with dm_rd=0, dm_rdata=0.
REQ-032 A read of an address being written in the same cycle SHALL return the old data; the new data SHALL be visible after the edge.
REQ-033 Addresses at or above DM_BYTES SHALL wrap modulo DM_BYTES.

Reset
REQ-034 While reset=1 at a rising edge, all DM bytes SHALL be cleared to 0 and any write that cycle SHALL be ignored; after reset, dm_rdata SHALL read 0 at every address.
REQ-035 ctrl and all ALU outputs SHALL be combinational and unaffected by reset.

Configuration
REQ-036 Macro ALU_CTRL_DM_BYTE_ACCESS_EN: when defined, lb 100000 SHALL decode as lw plus dmdatasize=1, sb 101000 SHALL decode as sw plus dmdatasize=1, and dm_len SHALL be honoured.
REQ-037 When ALU_CTRL_DM_BYTE_ACCESS_EN is undefined, opcodes 100000 and 101000 SHALL produce ctrl=0 and DM SHALL treat every access as a word access regardless of dm_len.

Verification
REQ-038 opcode=000000, funct=100000 -> ctrl regdst=1, regwre=1, aluctr=000, all other bits 0; opcode=111111 -> only pcwre=1; opcode=010101 -> ctrl=0.
REQ-039 alu_ctr=000, a=0x7FFFFFFF, b=1 -> alu_res=0x80000000, alu_wrctr=0; alu_ctr=001, a=b=5 -> alu_res=0, alu_zero=1.
REQ-040 alu_ctr=010, a=4, b=0x1 -> alu_res=0x10; alu_ctr=101, a=0xFFFFFFFF, b=0 -> alu_res=1; alu_ctr=111, a=9, b=0 -> alu_res=9, alu_wrctr=0.
REQ-041 Word write 0x11223344 to address 8, then word read of address 8 -> 0x11223344; byte read of address 9 -> 0x00000022.
REQ-042 Byte write of 0xAB to address 3, then byte read of address 3 -> 0xFFFFFFAB; word read of address 0 -> 0x000000AB.
REQ-043 Write data, assert reset for one edge, then read the same address -> 0; assert dm_wr during the reset cycle -> memory remains 0.
